// File: rtl/mem_bist_ctrl.sv
// BIST engine for the lab memory: clear test (0) then data=address test, with a compare pipeline.
// Defining MEM_BIST_INV_PATTERN_EN adds an inverted data=address write/read pass after RDA.
module mem_bist_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ERR_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

`ifdef MEM_BIST_INV_PATTERN_EN
    typedef enum logic [3:0] {IDLE, WR0, RD0, WRA, RDA, WRI, RDI, FLUSH, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR0, RD0, WRA, RDA, FLUSH, DONE} state_t;
`endif

    state_t              state, state_nxt;
    logic                busy_nxt, done_nxt, pass_nxt, read_nxt, write_nxt;
    logic [ERR_W-1:0]    err_nxt;
    logic [ADDR_W-1:0]   first_nxt, addr_nxt, addr_inc;
    logic [DATA_W-1:0]   data_in_nxt;
    logic                cmp_vld, cmp_vld_nxt;
    logic [ADDR_W-1:0]   cmp_addr, cmp_addr_nxt;
    logic [DATA_W-1:0]   cmp_exp, cmp_exp_nxt;
    logic                last;

    assign addr_inc = addr + ADDR_W'(1);
    assign last     = (addr == ADDR_MAX);

    // Next state and next values of all registered outputs; the address wraps to 0 exactly when a phase ends.
    always_comb begin
        state_nxt    = state;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        err_nxt      = err_count;
        first_nxt    = first_err_addr;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        addr_nxt     = addr;
        data_in_nxt  = '0;
        cmp_vld_nxt  = read;
        cmp_addr_nxt = addr;
        cmp_exp_nxt  = '0;

        // Check the data returned for last cycle's read
        if (cmp_vld && (data_out != cmp_exp)) begin
            if (err_count != ERR_MAX) err_nxt = err_count + ERR_W'(1);
            if (err_count == '0) first_nxt = cmp_addr;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WR0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    err_nxt   = '0;
                    first_nxt = '0;
                    addr_nxt  = '0;
                    write_nxt = 1'b1;
                end
            end
            WR0: begin
                addr_nxt = addr_inc;
                if (last) begin
                    state_nxt = RD0;
                    read_nxt  = 1'b1;
                end else begin
                    write_nxt = 1'b1;
                end
            end
            RD0: begin
                addr_nxt = addr_inc;
                if (last) begin
                    state_nxt   = WRA;
                    write_nxt   = 1'b1;
                    data_in_nxt = DATA_W'(addr_inc);
                end else begin
                    read_nxt = 1'b1;
                end
            end
            WRA: begin
                addr_nxt = addr_inc;
                if (last) begin
                    state_nxt = RDA;
                    read_nxt  = 1'b1;
                end else begin
                    write_nxt   = 1'b1;
                    data_in_nxt = DATA_W'(addr_inc);
                end
            end
            RDA: begin
                cmp_exp_nxt = DATA_W'(addr);
                addr_nxt    = addr_inc;
                if (last) begin
`ifdef MEM_BIST_INV_PATTERN_EN
                    state_nxt   = WRI;
                    write_nxt   = 1'b1;
                    data_in_nxt = ~DATA_W'(addr_inc);
`else
                    state_nxt = FLUSH;
`endif
                end else begin
                    read_nxt = 1'b1;
                end
            end
`ifdef MEM_BIST_INV_PATTERN_EN
            WRI: begin
                addr_nxt = addr_inc;
                if (last) begin
                    state_nxt = RDI;
                    read_nxt  = 1'b1;
                end else begin
                    write_nxt   = 1'b1;
                    data_in_nxt = ~DATA_W'(addr_inc);
                end
            end
            RDI: begin
                cmp_exp_nxt = ~DATA_W'(addr);
                addr_nxt    = addr_inc;
                if (last) begin
                    state_nxt = FLUSH;
                end else begin
                    read_nxt = 1'b1;
                end
            end
`endif
            FLUSH: begin
                // err_nxt already includes the final compare
                state_nxt = DONE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = (err_nxt == '0);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            read           <= 1'b0;
            write          <= 1'b0;
            addr           <= '0;
            data_in        <= '0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            cmp_exp        <= '0;
        end else begin
            state          <= state_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_nxt;
            first_err_addr <= first_nxt;
            read           <= read_nxt;
            write          <= write_nxt;
            addr           <= addr_nxt;
            data_in        <= data_in_nxt;
            cmp_vld        <= cmp_vld_nxt;
            cmp_addr       <= cmp_addr_nxt;
            cmp_exp        <= cmp_exp_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 32x8 memory model and injectable stuck-at data bits.
module tb_mem_bist_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 7;
    localparam int unsigned DEPTH  = 32;
`ifdef MEM_BIST_INV_PATTERN_EN
    localparam int unsigned PHASES = 3;
    localparam int unsigned ERR_B0 = 32;
`else
    localparam int unsigned PHASES = 2;
    localparam int unsigned ERR_B0 = 16;
`endif
    localparam int unsigned ERR_B7   = 64;
    localparam int unsigned BUSY_CYC = 2 * PHASES * DEPTH + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, pass, read, write;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr, addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out = '0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] and_mask = 8'hFF;
    logic [DATA_W-1:0] or_mask  = 8'h00;

    int wr_cnt, rd_cnt, wr_bad, rd_bad, conflicts, busy_cyc;
    int vectors     = 0;
    int miscompares = 0;

    mem_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .read           (read),
        .write          (write),
        .addr           (addr),
        .data_in        (data_in),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    // Expected write data for the idx-th write of a run: 0, then address, then inverted address
    function automatic logic [DATA_W-1:0] exp_wdata(input int idx);
        logic [DATA_W-1:0] k;
        k = DATA_W'(idx % DEPTH);
        if (idx < DEPTH)          return '0;
        else if (idx < 2 * DEPTH) return k;
        else                      return ~k;
    endfunction

    // Memory model plus bus-trace scoreboard; statistics restart on the edge that accepts start
    always @(posedge clk) begin
        if (rst_n && start && !busy) begin
            wr_cnt = 0; rd_cnt = 0; wr_bad = 0; rd_bad = 0; conflicts = 0; busy_cyc = 0;
        end else begin
            if (busy) busy_cyc++;
            if (read && write) conflicts++;
            if (!write && data_in != '0) wr_bad++;
            if (write) begin
                mem[addr] <= data_in;
                if (addr != ADDR_W'(wr_cnt % DEPTH) || data_in != exp_wdata(wr_cnt)) wr_bad++;
                wr_cnt++;
            end
            if (read) begin
                data_out <= (mem[addr] & and_mask) | or_mask;
                if (addr != ADDR_W'(rd_cnt % DEPTH)) rd_bad++;
                rd_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy),           0);
        chk({tag, "_done"},  32'(done),           0);
        chk({tag, "_pass"},  32'(pass),           0);
        chk({tag, "_err"},   32'(err_count),      0);
        chk({tag, "_first"}, 32'(first_err_addr), 0);
        chk({tag, "_read"},  32'(read),           0);
        chk({tag, "_write"}, 32'(write),          0);
        chk({tag, "_addr"},  32'(addr),           0);
        chk({tag, "_din"},   32'(data_in),        0);
    endtask

    // One full test run; start is either pulsed, held until done, or re-pulsed at cycle pulse_at
    task automatic run(input string tag, input logic [7:0] am, input logic [7:0] om,
                       input int exp_err, input int exp_first, input logic exp_pass,
                       input bit hold, input int pulse_at);
        int  n;
        bit  seen;
        and_mask = am;
        or_mask  = om;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        @(negedge clk);
        chk({tag, "_c1_busy"},  32'(busy),           1);
        chk({tag, "_c1_write"}, 32'(write),          1);
        chk({tag, "_c1_addr"},  32'(addr),           0);
        chk({tag, "_c1_done"},  32'(done),           0);
        chk({tag, "_c1_err"},   32'(err_count),      0);
        chk({tag, "_c1_first"}, 32'(first_err_addr), 0);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < int'(BUSY_CYC) + 20) begin
            @(negedge clk);
            n++;
            if (n == pulse_at) start = 1'b1;
            else if (!hold)    start = 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 32'(n),        BUSY_CYC + 1);
        chk({tag, "_busy_cyc"},   32'(busy_cyc), BUSY_CYC);
        chk({tag, "_wr_cnt"},     32'(wr_cnt),   PHASES * DEPTH);
        chk({tag, "_rd_cnt"},     32'(rd_cnt),   PHASES * DEPTH);
        chk({tag, "_wr_bad"},     32'(wr_bad),   0);
        chk({tag, "_rd_bad"},     32'(rd_bad),   0);
        chk({tag, "_conflict"},   32'(conflicts), 0);
        chk({tag, "_pass"},       32'(pass),     32'(exp_pass));
        chk({tag, "_err"},        32'(err_count), 32'(exp_err));
        chk({tag, "_first"},      32'(first_err_addr), 32'(exp_first));
        chk({tag, "_busy_end"},   32'(busy),     0);
        chk({tag, "_rw_end"},     32'({read, write}), 0);
        @(negedge clk);
        chk({tag, "_done_held"},  32'(done),     1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("clean",   8'hFF, 8'h00, 0,      0, 1'b1, 1'b0, 0);
        run("b0_sa0",  8'hFE, 8'h00, ERR_B0, 1, 1'b0, 1'b0, 0);
        run("b7_sa1",  8'hFF, 8'h80, ERR_B7, 0, 1'b0, 1'b0, 0);
        run("rerun",   8'hFF, 8'h00, 0,      0, 1'b1, 1'b0, 0);

        // Asynchronous abort in the middle of RD0
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("post_rst", 8'hFF, 8'h00, 0, 0, 1'b1, 1'b0, 0);
        run("hold",     8'hFF, 8'h00, 0, 0, 1'b1, 1'b1, 0);
        run("repulse",  8'hFF, 8'h00, 0, 0, 1'b1, 1'b0, 70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Synthesizable built-in self-test engine that drives the 32x8 lab memory through the same read/write/addr/data_in/data_out bus as the testbench.
- Runs the clear test (write 0, read and check 0) and then the data=address test (write i, read and check i) entirely in hardware.
- Reports pass/fail, an error count and the address of the first failure.
- Sits directly upstream of the memory, in place of the testbench driver, behind a single start/done handshake.

Parameters:
- ADDR_W, 5, memory address width; depth = 2**ADDR_W
- DATA_W, 8, memory data width; ADDR_W <= DATA_W required
- ERR_W, 7, error counter width; saturates at 2**ERR_W-1

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin test; sampled only in IDLE or DONE
- busy  output  1  test in progress
- done  output  1  test complete; level, held until next accepted start or reset
- pass  output  1  valid when done=1; 1 = zero errors
- err_count  output  ERR_W  number of miscompares, saturating
- first_err_addr  output  ADDR_W  address of first miscompare; 0 if none
- read  output  1  memory read strobe
- write  output  1  memory write strobe
- addr  output  ADDR_W  memory address
- data_in  output  DATA_W  write data to memory
- data_out  input  DATA_W  read data from memory

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Memory contract: write captured on the clk edge with write=1. For a read, data_out is valid the cycle after the read=1 cycle and holds until the next read.
- Reset state: all outputs 0, state IDLE, counters 0. rst_n low mid-test aborts immediately: read=write=0, busy=done=pass=0. No resume.
- States: IDLE -> WR0 -> RD0 -> WRA -> RDA -> FLUSH -> DONE.
  - IDLE/DONE with start=1: clear err_count, first_err_addr, done and pass; go to WR0 with addr=0.
  - start is ignored while busy.
- WR0: write=1, data_in=0, addr increments 0..2**ADDR_W-1, one write per cycle. Exits to RD0 after the last address.
- RD0: read=1, addr 0..max, expected=0. Exits to WRA.
- WRA: write=1, data_in = zero-extended addr. Exits to RDA.
- RDA: read=1, expected = zero-extended addr. Exits to FLUSH.
- Compare pipeline:
  - Each read cycle registers cmp_vld=1, cmp_addr and cmp_exp.
  - In the following cycle data_out is compared with cmp_exp. On mismatch, err_count increments (saturating) at the end of that cycle.
  - If this is the first error, first_err_addr <= cmp_addr.
  - Compares overlap the next read or write cycle. FLUSH exists only to complete the final compare.
- busy=1 in WR0 through FLUSH.
- DONE: busy=0, done=1, pass=(err_count==0), read=write=0.
- Latency (default params): start sampled at edge E0. WR0 runs cycles 1-32, RD0 33-64, WRA 65-96, RDA 97-128, FLUSH 129. done=1 from the edge ending cycle 129 onward.
- Outside write states data_in=0. read and write are never both 1. addr wraps only at phase boundaries.

Optional Feature:
- Macro: MEM_BIST_INV_PATTERN_EN.
- Defined: two phases are inserted after RDA.
  - WRI writes the bitwise inverse of the zero-extended addr.
  - RDI reads and checks the same value.
  - Order: RDA -> WRI -> RDI -> FLUSH. FLUSH is cycle 193; done rises after it.
- Undefined: the phases, their logic and their state encodings are absent; timing is as in Behaviour.

Test Plan:
- Fault-free memory, start pulse at E0 -> busy for 129 cycles, then done=1, pass=1, err_count=0, first_err_addr=0. Bus trace: 32 writes of 0, 32 reads, 32 writes data=addr, 32 reads.
- Memory model with data_out[0] stuck-at-0 -> clear test passes. Data=addr test fails at the 16 odd addresses -> err_count=16, first_err_addr=1, pass=0.
- data_out[7] stuck-at-1 -> every compare fails -> err_count=64, first_err_addr=0, pass=0.
- rst_n low at cycle 50 (mid RD0) -> all outputs 0 asynchronously. After release, new start -> full clean run with pass=1 at 129 cycles.
- start held high continuously, and start re-pulsed at cycle 70 -> no restart while busy. One run completes; a start in DONE launches a second run and clears the previous results.
- With MEM_BIST_INV_PATTERN_EN and a fault-free memory -> 193 busy cycles, WRI writes 0xFF at addr 0 and 0xE0 at addr 31, pass=1.
